// File: rtl/wb_cmd_master_pkg.sv
// Shared constants for the SPI-to-Wishbone command master: FSM state
// encodings, the command-byte write flag position and word/reply sizes.
package wb_cmd_master_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WDATA = 3'd1;
    localparam logic [2:0] ST_WB_WR = 3'd2;
    localparam logic [2:0] ST_WB_RD = 3'd3;
    localparam logic [2:0] ST_REPLY = 3'd4;

    localparam int CMD_W_BIT   = 7;
    localparam int WORD_BYTES  = 4;
    localparam int REPLY_BYTES = 4;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone initiator fed by the SPI slave byte stream. A frame starts with a
// command byte (bit 7 = write, low bits = address). Writes carry 4-byte
// big-endian words, one wb write per word with auto-incrementing address.
// Reads issue one wb read and return the word as 4 reply bytes, MSB first.
// A first-of-frame byte arriving while a wb cycle is open is parked and
// acted on once that cycle finishes.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int          ADDR_W    = 7,
    parameter int          TIMEOUT   = 15,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_first,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [31:0]       wb_wdata,
    input  logic [31:0]       wb_rdata,
    output logic              wb_we,
    output logic              wb_cyc,
    input  logic              wb_ack,
    output logic              busy_o,
    output logic              err_o,
    input  logic              err_clr
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       shift;
    logic [1:0]        byte_cnt;
    logic [7:0]        tcnt;
    logic              pend_valid;
    logic [7:0]        pend_cmd;

    logic              take_first;
    logic              cyc_busy;
    logic              start_cmd;
    logic [7:0]        cmd;
    logic              timeout_hit;
    logic              last_byte;
    logic              cyc_done;

    // Decode which command (live byte or parked one) starts now and when the open cycle ends
    always_comb begin
        take_first  = in_valid & in_first;
        cyc_busy    = (state == ST_WB_WR) || (state == ST_WB_RD);
        start_cmd   = (take_first & ~cyc_busy) | ((state == ST_IDLE) & pend_valid);
        cmd         = (take_first & ~cyc_busy) ? in_data : pend_cmd;
        timeout_hit = wb_cyc & ~wb_ack & (tcnt == 8'(TIMEOUT - 1));
        cyc_done    = wb_cyc & (wb_ack | timeout_hit);
        last_byte   = (byte_cnt == 2'(WORD_BYTES - 1));
    end

    // Frame FSM, byte shifter, byte counter, timeout counter and wb outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            shift      <= '0;
            byte_cnt   <= '0;
            tcnt       <= '0;
            pend_valid <= 1'b0;
            pend_cmd   <= '0;
            out_valid  <= 1'b0;
            wb_cyc     <= 1'b0;
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_wdata   <= '0;
        end else if (cyc_busy) begin
            if (take_first) begin
                pend_valid <= 1'b1;
                pend_cmd   <= in_data;
            end
            if (cyc_done) begin
                wb_cyc <= 1'b0;
                wb_we  <= 1'b0;
                if (state == ST_WB_WR) begin
                    addr  <= addr + ADDR_W'(1);
                    state <= (pend_valid | take_first) ? ST_IDLE : ST_WDATA;
                end else begin
                    shift    <= wb_ack ? wb_rdata : ERR_RDATA;
                    byte_cnt <= '0;
                    if (pend_valid | take_first) begin
                        state <= ST_IDLE;
                    end else begin
                        state     <= ST_REPLY;
                        out_valid <= 1'b1;
                    end
                end
            end else begin
                tcnt <= tcnt + 8'd1;
            end
        end else if (start_cmd) begin
            pend_valid <= 1'b0;
            byte_cnt   <= '0;
            out_valid  <= 1'b0;
            addr       <= cmd[ADDR_W-1:0];
            if (cmd[CMD_W_BIT]) begin
                state <= ST_WDATA;
            end else begin
                state   <= ST_WB_RD;
                wb_cyc  <= 1'b1;
                wb_we   <= 1'b0;
                wb_addr <= cmd[ADDR_W-1:0];
                tcnt    <= '0;
            end
        end else if (state == ST_WDATA) begin
            if (in_valid) begin
                shift    <= {shift[23:0], in_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    state    <= ST_WB_WR;
                    wb_cyc   <= 1'b1;
                    wb_we    <= 1'b1;
                    wb_addr  <= addr;
                    wb_wdata <= {shift[23:0], in_data};
                    tcnt     <= '0;
                end
            end
        end else if (state == ST_REPLY) begin
            if (out_valid & out_ready) begin
                shift    <= {shift[23:0], 8'h00};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'(REPLY_BYTES - 1)) begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            end
        end
    end

    // Sticky error flag: wb timeout or data byte arriving during a write cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o <= 1'b0;
        end else if (err_clr) begin
            err_o <= 1'b0;
        end else if (timeout_hit || ((state == ST_WB_WR) && in_valid && !in_first)) begin
            err_o <= 1'b1;
        end
    end

    assign busy_o   = wb_cyc;
    assign out_data = out_valid ? shift[31:24] : 8'h00;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: drives SPI-style byte frames, models a
// Wishbone slave with optional 1-cycle ack, logs completed wb cycles and
// checks writes, reads, reply flow control, timeout, abort and reset.
module tb_wb_cmd_master;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_first;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic        busy_o;
    logic        err_o;
    logic        err_clr;

    logic        ack_en;
    int          errors;
    int          checks;
    int          cyc_cnt;
    int          log_n;
    int          base;
    logic [6:0]  log_addr  [0:15];
    logic        log_we    [0:15];
    logic [31:0] log_wdata [0:15];
    logic [31:0] exp_word;

    wb_cmd_master #(
        .ADDR_W    (7),
        .TIMEOUT   (15),
        .ERR_RDATA (32'hFFFF_FFFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_addr   (wb_addr),
        .wb_wdata  (wb_wdata),
        .wb_rdata  (wb_rdata),
        .wb_we     (wb_we),
        .wb_cyc    (wb_cyc),
        .wb_ack    (wb_ack),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .err_clr   (err_clr)
    );

    // 100 MHz free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model: acks one cycle after wb_cyc is seen, never back-to-back
    always @(posedge clk or negedge rst) begin
        if (!rst) wb_ack <= 1'b0;
        else      wb_ack <= ack_en & wb_cyc & ~wb_ack;
    end

    // Monitor: count cycles with wb_cyc high and log every acknowledged cycle
    always @(posedge clk) begin
        if (wb_cyc) cyc_cnt = cyc_cnt + 1;
        if (wb_cyc && wb_ack && log_n < 16) begin
            log_addr[log_n]  = wb_addr;
            log_we[log_n]    = wb_we;
            log_wdata[log_n] = wb_wdata;
            log_n = log_n + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input logic first);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        in_first = first;
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) apply_stimulus(w[31-8*i -: 8], 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        errors = 0; checks = 0; cyc_cnt = 0; log_n = 0; base = 0;
        rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_first = 1'b0;
        out_ready = 1'b0; wb_rdata = 32'h0; err_clr = 1'b0; ack_en = 1'b1;
        exp_word = 32'h0;
        $display("[TB] start");

        // reset state
        repeat (3) @(negedge clk);
        check_output("rst_cyc",   {31'd0, wb_cyc},    32'd0);
        check_output("rst_busy",  {31'd0, busy_o},    32'd0);
        check_output("rst_oval",  {31'd0, out_valid}, 32'd0);
        check_output("rst_err",   {31'd0, err_o},     32'd0);
        check_output("rst_odata", {24'd0, out_data},  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // single write, addr 1, data 00001F07
        cyc_cnt = 0; base = log_n;
        apply_stimulus(8'h81, 1'b1);
        apply_stimulus(8'h00, 1'b0);
        apply_stimulus(8'h00, 1'b0);
        apply_stimulus(8'h1F, 1'b0);
        apply_stimulus(8'h07, 1'b0);
        check_output("w1_cyc_rise", {31'd0, wb_cyc}, 32'd1);
        check_output("w1_busy",     {31'd0, busy_o}, 32'd1);
        repeat (6) @(negedge clk);
        check_output("w1_count", log_n - base,           1);
        check_output("w1_addr",  {25'd0, log_addr[base]}, 32'd1);
        check_output("w1_we",    {31'd0, log_we[base]},   32'd1);
        check_output("w1_data",  log_wdata[base],         32'h0000_1F07);
        check_output("w1_cyclen", cyc_cnt,                2);
        check_output("w1_err",   {31'd0, err_o},          32'd0);

        // two-word write starting at 0x7F, address wraps to 0
        base = log_n;
        apply_stimulus(8'hFF, 1'b1);
        send_word(32'h0000_0007);
        send_word(32'h0012_000A);
        check_output("w2_count", log_n - base,              2);
        check_output("w2_addr0", {25'd0, log_addr[base]},   32'h7F);
        check_output("w2_data0", log_wdata[base],           32'h0000_0007);
        check_output("w2_addr1", {25'd0, log_addr[base+1]}, 32'h00);
        check_output("w2_data1", log_wdata[base+1],         32'h0012_000A);

        // read addr 1, reply held while out_ready low
        base = log_n; exp_word = 32'h1234_5678; wb_rdata = exp_word;
        apply_stimulus(8'h01, 1'b1);
        wait_out_valid("r1_valid");
        check_output("r1_addr", {25'd0, log_addr[base]}, 32'd1);
        check_output("r1_we",   {31'd0, log_we[base]},   32'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (2) @(negedge clk);
            check_output("r1_hold_valid", {31'd0, out_valid}, 32'd1);
            check_output("r1_byte", {24'd0, out_data}, {24'd0, exp_word[31-8*i -: 8]});
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check_output("r1_done", {31'd0, out_valid}, 32'd0);

        // read timeout: no ack, 15 cycles, error word returned
        ack_en = 1'b0; cyc_cnt = 0;
        apply_stimulus(8'h02, 1'b1);
        wait_out_valid("to_valid");
        check_output("to_cyclen", cyc_cnt, 15);
        check_output("to_cyc",    {31'd0, wb_cyc}, 32'd0);
        check_output("to_err",    {31'd0, err_o},  32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_output("to_byte", {24'd0, out_data}, 32'hFF);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_output("to_done", {31'd0, out_valid}, 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("to_errclr", {31'd0, err_o}, 32'd0);
        ack_en = 1'b1;

        // partial write aborted by a new read frame
        base = log_n; wb_rdata = 32'hCAFE_F00D;
        apply_stimulus(8'h80, 1'b1);
        apply_stimulus(8'hAA, 1'b0);
        apply_stimulus(8'hBB, 1'b0);
        apply_stimulus(8'h01, 1'b1);
        wait_out_valid("ab_valid");
        check_output("ab_count", log_n - base,           1);
        check_output("ab_addr",  {25'd0, log_addr[base]}, 32'd1);
        check_output("ab_we",    {31'd0, log_we[base]},   32'd0);
        check_output("ab_byte0", {24'd0, out_data},       32'hCA);
        apply_stimulus(8'h85, 1'b1);
        check_output("ab_reply_abort", {31'd0, out_valid}, 32'd0);

        // overrun: data byte during write cycle is dropped
        base = log_n;
        for (int i = 0; i < 4; i++) apply_stimulus(8'h11 * (i + 1), 1'b0);
        apply_stimulus(8'h99, 1'b0);
        check_output("ov_err", {31'd0, err_o}, 32'd1);
        repeat (4) @(negedge clk);
        send_word(32'h5566_7788);
        check_output("ov_count", log_n - base,              2);
        check_output("ov_data0", log_wdata[base],           32'h1122_3344);
        check_output("ov_addr1", {25'd0, log_addr[base+1]}, 32'd6);
        check_output("ov_data1", log_wdata[base+1],         32'h5566_7788);

        // async reset while wb_cyc is high
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(8'hA0 + 8'(i), 1'b0);
        check_output("ar_pre_cyc", {31'd0, wb_cyc}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_output("ar_cyc",  {31'd0, wb_cyc}, 32'd0);
        check_output("ar_busy", {31'd0, busy_o}, 32'd0);
        check_output("ar_err",  {31'd0, err_o},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        ack_en = 1'b1;

        // async reset while a reply byte is offered
        apply_stimulus(8'h03, 1'b1);
        wait_out_valid("ar2_valid");
        #2 rst = 1'b0;
        #1;
        check_output("ar2_oval",  {31'd0, out_valid}, 32'd0);
        check_output("ar2_odata", {24'd0, out_data},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
